vga_scanout: RTL

Display-side stage of the QQVGA frame buffer path: reads the 160x120 1-bit frame buffer that `filler` writes, and drives a 640x480@60 Hz VGA output. Each stored pixel is replicated 4x horizontally and 4x vertically. The block generates all VGA timing, issues read addresses to the frame buffer's synchronous read port, and delays the sync signals so they stay aligned with the returned pixel data. `vblank` tells the writer side when the frame is not being scanned.

---
 rtl/vga_scanout.sv | 102 ++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout of a 160x120 1-bit frame buffer, 4x pixel replication.
// Reads a synchronous-RAM port and delays sync/blank so they line up with returned pixels.
module vga_scanout #(
  parameter int ADDR_WIDTH = 15,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic                  clk_25,
  input  logic                  reset_n,
  input  logic                  pixel_in,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  vga_r,
  output logic                  vga_g,
  output logic                  vga_b,
  output logic                  vblank
);

  localparam logic [9:0] H_ACT    = 10'd640;
  localparam logic [9:0] H_SYNC_S = 10'd656;
  localparam logic [9:0] H_SYNC_E = 10'd752;
  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_S = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam int         STAGES   = 2;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic vb;
  } flags_t;

  localparam flags_t FLAGS_RST = '{act: 1'b0, hs: 1'b1, vs: 1'b1, vb: 1'b0};

  logic [9:0]                h, v;
  logic [ADDR_WIDTH-1:0]     row_base;
  flags_t                    cur;
  flags_t [STAGES:1]         flag_pipe;
  logic                      pix;

  always_comb begin
    cur     = FLAGS_RST;
    cur.act = (h < H_ACT) && (v < V_ACT);
    cur.hs  = !((h >= H_SYNC_S) && (h < H_SYNC_E));
    cur.vs  = !((v >= V_SYNC_S) && (v < V_SYNC_E));
    cur.vb  = (v >= V_ACT);
  end

  // row_base tracks (v>>2)*160 by stepping once every 4 active lines
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      h        <= '0;
      v        <= '0;
      row_base <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      if (v == V_LAST) begin
        v        <= '0;
        row_base <= '0;
      end else begin
        v <= v + 10'd1;
        if ((v[1:0] == 2'd3) && (v < V_ACT - 10'd1))
          row_base <= row_base + ADDR_WIDTH'(160);
      end
    end else begin
      h <= h + 10'd1;
    end
  end

  assign pix = pixel_in & flag_pipe[STAGES].act;

  // Flags ride alongside the RAM read so outputs see pixel and sync together
  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      read_addr <= '0;
      flag_pipe <= {STAGES{FLAGS_RST}};
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      vblank    <= 1'b0;
      vga_r     <= 1'b0;
      vga_g     <= 1'b0;
      vga_b     <= 1'b0;
    end else begin
      read_addr    <= cur.act ? row_base + ADDR_WIDTH'(h[9:2]) : '0;
      flag_pipe[1] <= cur;
      for (int s = 2; s <= STAGES; s++) flag_pipe[s] <= flag_pipe[s-1];
      hsync  <= flag_pipe[STAGES].hs;
      vsync  <= flag_pipe[STAGES].vs;
      vblank <= flag_pipe[STAGES].vb;
      vga_r  <= pix;
      vga_g  <= pix;
      vga_b  <= pix;
    end
  end

endmodule
